// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with configurable depth, data width and
// NUM_WB write-back ports. Entries are allocated in order at the tail.
// Results arrive out of order on the write-back ports. Entries retire in
// order from the head, at most one per cycle. Retiring a mispredicted
// branch squashes the whole buffer.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   alloc_*              allocation request/handshake from the decoder
//   wb_valid/tag/data    NUM_WB packed write-back ports (port k at slice k)
//   src1_*, src2_*       combinational operand lookup with write-back bypass
//   store_ready          LSBuf accepts a store commit this cycle
//   commit_*             registered one-cycle retirement record
//   flush                registered one-cycle squash pulse
//   count                number of occupied entries
module rob_multiport #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int NUM_WB = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [1:0]                 alloc_op,
  input  logic [REG_W-1:0]           alloc_reg,
  output logic [IDX_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [IDX_W-1:0]           src1_tag,
  input  logic [IDX_W-1:0]           src2_tag,
  output logic                       src1_ready,
  output logic                       src2_ready,
  output logic [DATA_W-1:0]          src1_data,
  output logic [DATA_W-1:0]          src2_data,
  input  logic                       store_ready,
  output logic                       commit_valid,
  output logic [1:0]                 commit_op,
  output logic [REG_W-1:0]           commit_reg,
  output logic [DATA_W-1:0]          commit_data,
  output logic [IDX_W-1:0]           commit_tag,
  output logic                       flush,
  output logic [IDX_W:0]             count
);

  localparam logic [1:0]     OP_STORE  = 2'd1;
  localparam logic [1:0]     OP_BRANCH = 2'd2;
  localparam logic [1:0]     OP_NOP    = 2'd3;
  localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  rdy;
  logic [1:0]        op_q   [DEPTH];
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;

  logic [DEPTH-1:0]  wb_hit;
  logic [DATA_W-1:0] wb_val [DEPTH];
  logic              do_alloc;
  logic              do_commit;
  logic              do_flush;

  // Handshake depends only on the registered count, so a same-cycle commit
  // never opens a slot early.
  assign alloc_ready = (count != FULL_CNT);
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_commit   = busy[head] & rdy[head] &
                       ((op_q[head] != OP_STORE) | store_ready);
  assign do_flush    = do_commit & (op_q[head] == OP_BRANCH) & data_q[head][0];

  // Resolve write-backs per entry; ports scanned high to low so the lowest
  // port index is the last to overwrite and therefore wins.
  always_comb begin
    logic m;
    wb_hit = '0;
    m      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wb_val[i] = '0;
      for (int k = NUM_WB-1; k >= 0; k--) begin
        m         = wb_valid[k] & (wb_tag[k*IDX_W +: IDX_W] == IDX_W'(i));
        wb_hit[i] = wb_hit[i] | m;
        wb_val[i] = m ? wb_data[k*DATA_W +: DATA_W] : wb_val[i];
      end
    end
  end

  // Operand lookup: stored entry first, then overridden by any same-cycle
  // write-back to that tag (lowest port wins), even for a non-busy entry.
  always_comb begin
    logic m1;
    logic m2;
    m1         = 1'b0;
    m2         = 1'b0;
    src1_ready = busy[src1_tag] & rdy[src1_tag];
    src1_data  = busy[src1_tag] ? data_q[src1_tag] : '0;
    src2_ready = busy[src2_tag] & rdy[src2_tag];
    src2_data  = busy[src2_tag] ? data_q[src2_tag] : '0;
    for (int k = NUM_WB-1; k >= 0; k--) begin
      m1         = wb_valid[k] & (wb_tag[k*IDX_W +: IDX_W] == src1_tag);
      m2         = wb_valid[k] & (wb_tag[k*IDX_W +: IDX_W] == src2_tag);
      src1_ready = src1_ready | m1;
      src1_data  = m1 ? wb_data[k*DATA_W +: DATA_W] : src1_data;
      src2_ready = src2_ready | m2;
      src2_data  = m2 ? wb_data[k*DATA_W +: DATA_W] : src2_data;
    end
  end

  // Entry array, pointers, count and registered commit/flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      rdy          <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_op    <= 2'd0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
      flush        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= 2'd0;
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      commit_valid <= do_commit;
      flush        <= do_flush;
      if (do_commit) begin
        commit_op   <= op_q[head];
        commit_reg  <= reg_q[head];
        commit_data <= data_q[head];
        commit_tag  <= head;
      end
      if (do_flush) begin
        // Squash everything, including an allocation offered this cycle.
        busy  <= '0;
        rdy   <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_hit[i] && busy[i]) begin
            rdy[i]    <= 1'b1;
            data_q[i] <= wb_val[i];
          end
        end
        if (do_commit) begin
          busy[head]   <= 1'b0;
          rdy[head]    <= 1'b0;
          data_q[head] <= '0;
          head         <= head + IDX_W'(1);
        end
        // Tail entry is never busy when allocation is allowed, so this
        // cannot collide with the write-back or commit updates above.
        if (do_alloc) begin
          busy[tail]   <= 1'b1;
          rdy[tail]    <= (alloc_op == OP_NOP);
          op_q[tail]   <= alloc_op;
          reg_q[tail]  <= alloc_reg;
          data_q[tail] <= '0;
          tail         <= tail + IDX_W'(1);
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + (IDX_W+1)'(1);
          2'b01:   count <= count - (IDX_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed testbench for rob_multiport (DEPTH 16, DATA_W 32, NUM_WB 3).
module tb_rob_multiport;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid, alloc_ready;
  logic [1:0]  alloc_op;
  logic [4:0]  alloc_reg;
  logic [3:0]  alloc_tag;
  logic [2:0]  wb_valid;
  logic [11:0] wb_tag;
  logic [95:0] wb_data;
  logic [3:0]  src1_tag, src2_tag;
  logic        src1_ready, src2_ready;
  logic [31:0] src1_data, src2_data;
  logic        store_ready;
  logic        commit_valid;
  logic [1:0]  commit_op;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;
  logic        flush;
  logic [4:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  rob_multiport dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .store_ready(store_ready),
    .commit_valid(commit_valid), .commit_op(commit_op), .commit_reg(commit_reg),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_op    = 2'd0;
    alloc_reg   = 5'd0;
    wb_valid    = 3'b000;
    wb_tag      = 12'h000;
    wb_data     = 96'h0;
    src1_tag    = 4'd0;
    src2_tag    = 4'd0;
    store_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic set_wb(input int k, input logic [3:0] t, input logic [31:0] d);
    wb_valid[k]        = 1'b1;
    wb_tag[k*4 +: 4]   = t;
    wb_data[k*32 +: 32] = d;
  endtask

  logic [3:0] exp_tag;
  int         seen;

  initial begin
    idle();
    #1 rst = 1'b1;
    #2;
    // Reset state
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    #4 rst = 1'b0;

    // In-order commit of out-of-order results
    alloc_valid = 1'b1; alloc_op = 2'd0;
    alloc_reg = 5'd3; #1 chk("a0_tag", alloc_tag, 0); tick();
    alloc_reg = 5'd5; chk("a1_tag", alloc_tag, 1); tick();
    alloc_reg = 5'd7; chk("a2_tag", alloc_tag, 2); tick();
    alloc_valid = 1'b0;
    chk("a_count", count, 3);
    set_wb(0, 4'd2, 32'h30); tick(); wb_valid = 3'b000;
    chk("wb2_nocommit", commit_valid, 0);
    src1_tag = 4'd2; #1;
    chk("lk2_ready", src1_ready, 1);
    chk("lk2_data", src1_data, 32'h30);
    set_wb(0, 4'd0, 32'h10); tick(); wb_valid = 3'b000;
    chk("wb0_no_same_edge_commit", commit_valid, 0);
    set_wb(0, 4'd1, 32'h20); tick(); wb_valid = 3'b000;
    chk("c0_valid", commit_valid, 1);
    chk("c0_reg", commit_reg, 3);
    chk("c0_data", commit_data, 32'h10);
    chk("c0_tag", commit_tag, 0);
    tick();
    chk("c1_valid", commit_valid, 1);
    chk("c1_reg", commit_reg, 5);
    chk("c1_data", commit_data, 32'h20);
    chk("c1_tag", commit_tag, 1);
    tick();
    chk("c2_valid", commit_valid, 1);
    chk("c2_reg", commit_reg, 7);
    chk("c2_data", commit_data, 32'h30);
    chk("c2_tag", commit_tag, 2);
    chk("c2_count", count, 0);
    tick();
    chk("c3_idle", commit_valid, 0);

    // Fill to DEPTH, reject a 17th, free one, wrap
    do_reset();
    alloc_valid = 1'b1; alloc_op = 2'd0;
    for (int i = 0; i < 16; i++) begin
      alloc_reg = 5'(i);
      #1 chk("full_tag", alloc_tag, 64'(i));
      tick();
    end
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    alloc_reg = 5'd20; tick();
    chk("a17_count", count, 16);
    chk("a17_tag", alloc_tag, 0);
    set_wb(1, 4'd0, 32'h7); tick(); wb_valid = 3'b000;
    chk("fw_nocommit", commit_valid, 0);
    chk("fw_ready", alloc_ready, 0);
    tick();
    chk("fc_valid", commit_valid, 1);
    chk("fc_tag", commit_tag, 0);
    chk("fc_data", commit_data, 32'h7);
    chk("fc_ready", alloc_ready, 1);
    chk("fc_count", count, 15);
    chk("wrap_tag", alloc_tag, 0);
    tick(); alloc_valid = 1'b0;
    chk("wrap_count", count, 16);
    chk("wrap_ready", alloc_ready, 0);
    exp_tag = 4'd1; seen = 0;
    for (int c = 0; c < 40 && seen < 16; c++) begin
      wb_valid = 3'b000;
      if (c < 5) begin
        for (int k = 0; k < 3; k++) set_wb(k, 4'(3*c+k+1), 32'h1000 + 32'(3*c+k+1)*32'h10);
      end else if (c == 5) begin
        set_wb(0, 4'd0, 32'h1000);
      end
      tick();
      if (commit_valid) begin
        chk("drain_tag", commit_tag, exp_tag);
        chk("drain_data", commit_data, 32'h1000 + 32'(exp_tag)*32'h10);
        chk("drain_reg", commit_reg, (exp_tag == 4'd0) ? 64'd20 : 64'(exp_tag));
        exp_tag = exp_tag + 4'd1;
        seen++;
      end
    end
    wb_valid = 3'b000;
    chk("drain_seen", seen, 16);
    chk("drain_count", count, 0);

    // Same-tag write-back on ports 0 and 2: port 0 wins, bypass visible
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin alloc_reg = 5'(i + 1); tick(); end
    alloc_valid = 1'b0;
    set_wb(0, 4'd4, 32'hA); set_wb(2, 4'd4, 32'hB);
    src1_tag = 4'd4; src2_tag = 4'd3; #1;
    chk("byp_ready", src1_ready, 1);
    chk("byp_data", src1_data, 32'hA);
    chk("byp_other_ready", src2_ready, 0);
    chk("byp_other_data", src2_data, 0);
    tick(); wb_valid = 3'b000;
    set_wb(1, 4'd9, 32'hEE); #1;
    chk("stored_ready", src1_ready, 1);
    chk("stored_data", src1_data, 32'hA);
    tick(); wb_valid = 3'b000;
    src2_tag = 4'd9; #1;
    chk("nonbusy_ready", src2_ready, 0);
    chk("nonbusy_data", src2_data, 0);

    // Store held off by store_ready
    do_reset();
    alloc_valid = 1'b1; alloc_op = 2'd1; alloc_reg = 5'd0; tick();
    alloc_valid = 1'b0;
    set_wb(2, 4'd0, 32'h77); tick(); wb_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold", commit_valid, 0);
    end
    store_ready = 1'b1; tick(); store_ready = 1'b0;
    chk("st_valid", commit_valid, 1);
    chk("st_op", commit_op, 1);
    chk("st_data", commit_data, 32'h77);
    tick();
    chk("st_done", commit_valid, 0);

    // Correctly predicted branch: commit without flush
    do_reset();
    alloc_valid = 1'b1; alloc_op = 2'd2; tick(); alloc_valid = 1'b0;
    set_wb(0, 4'd0, 32'h0); tick(); wb_valid = 3'b000;
    tick();
    chk("br_ok_valid", commit_valid, 1);
    chk("br_ok_flush", flush, 0);
    chk("br_ok_op", commit_op, 2);

    // Mispredicted branch at tag 5 with younger entries and a live alloc
    do_reset();
    alloc_valid = 1'b1;
    alloc_op = 2'd3;
    for (int i = 0; i < 5; i++) tick();
    alloc_op = 2'd2; tick();
    alloc_op = 2'd0; alloc_reg = 5'd11; tick();
    alloc_reg = 5'd12; tick();
    alloc_valid = 1'b0;
    chk("br_pre_count", count, 3);
    set_wb(1, 4'd5, 32'h1); tick(); wb_valid = 3'b000;
    alloc_valid = 1'b1; alloc_op = 2'd0; alloc_reg = 5'd9;
    tick(); alloc_valid = 1'b0;
    chk("br_flush", flush, 1);
    chk("br_valid", commit_valid, 1);
    chk("br_tag", commit_tag, 5);
    chk("br_count", count, 0);
    chk("br_alloc_tag", alloc_tag, 0);
    src1_tag = 4'd6; src2_tag = 4'd7; #1;
    chk("br_lk1", src1_ready, 0);
    chk("br_lk2", src2_ready, 0);
    tick();
    chk("br_flush_off", flush, 0);
    chk("br_valid_off", commit_valid, 0);

    // Asynchronous reset with a commit in flight
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin alloc_reg = 5'(i); tick(); end
    alloc_valid = 1'b0;
    set_wb(0, 4'd0, 32'h5); set_wb(1, 4'd1, 32'h6); tick(); wb_valid = 3'b000;
    tick();
    chk("ar_pre_valid", commit_valid, 1);
    chk("ar_pre_count", count, 6);
    rst = 1'b1; #1;
    chk("ar_valid", commit_valid, 0);
    chk("ar_flush", flush, 0);
    chk("ar_count", count, 0);
    chk("ar_ready", alloc_ready, 1);
    chk("ar_tag", alloc_tag, 0);
    chk("ar_cdata", commit_data, 0);
    src1_tag = 4'd1; #1;
    chk("ar_lookup", src1_ready, 0);
    #1 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
